bip_run_controller: RTL and testbench

//  Run/step/halt sequencer for the BIP core. Sits between the instruction decoder and
//  the datapath: gates WrPC/WrAcc/WrRam/RdRam strobes so the core only advances when

---
 rtl/bip_run_controller.sv | 125 ++++++++++++
 tb/tb_bip_run_controller.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bip_run_controller.sv
// bip_run_controller: run/step/halt sequencer for the BIP core.
// Ports: clock, reset (sync, active-high); host cmd_start/cmd_step/cmd_halt;
//   Opcode and decoder strobes WrPC_in/WrAcc_in/WrRam_in/RdRam_in in;
//   gated WrPC/WrAcc/WrRam/RdRam, cpu_en, busy, halted, done,
//   halt_cause, cycle_count, instr_count out.
module bip_run_controller #(
  parameter logic [4:0]       HLT_OPCODE = 5'b00000,
  parameter int               CNT_W      = 16,
  parameter logic [CNT_W-1:0] MAX_CYCLES = {CNT_W{1'b1}}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_start,
  input  logic             cmd_step,
  input  logic             cmd_halt,
  input  logic [4:0]       Opcode,
  input  logic             WrPC_in,
  input  logic             WrAcc_in,
  input  logic             WrRam_in,
  input  logic             RdRam_in,
  output logic             WrPC,
  output logic             WrAcc,
  output logic             WrRam,
  output logic             RdRam,
  output logic             cpu_en,
  output logic             busy,
  output logic             halted,
  output logic             done,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_HALTED
  } state_t;

  localparam logic [1:0] C_NONE = 2'b00;
  localparam logic [1:0] C_HLT  = 2'b01;
  localparam logic [1:0] C_HOST = 2'b10;
  localparam logic [1:0] C_WDOG = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] WD_LAST = MAX_CYCLES - CNT_ONE;
  localparam bit               WD_ON   = (MAX_CYCLES != '0);

  state_t state;
  logic   is_hlt;
  logic   wd_hit;

  assign is_hlt = (Opcode == HLT_OPCODE);
  assign cpu_en = busy && !is_hlt;
  assign wd_hit = WD_ON && (cycle_count == WD_LAST);

  assign WrPC  = WrPC_in  && cpu_en;
  assign WrAcc = WrAcc_in && cpu_en;
  assign WrRam = WrRam_in && cpu_en;
  assign RdRam = RdRam_in && cpu_en;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      halted      <= 1'b0;
      done        <= 1'b0;
      halt_cause  <= C_NONE;
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_halt) begin
            state      <= S_HALTED;
            halted     <= 1'b1;
            done       <= 1'b1;
            halt_cause <= C_HOST;
          end else if (cmd_step || cmd_start) begin
            state       <= cmd_step ? S_STEP : S_RUN;
            busy        <= 1'b1;
            cycle_count <= '0;
            instr_count <= '0;
          end
        end
        S_RUN, S_STEP: begin
          if (cycle_count != CNT_MAX)
            cycle_count <= cycle_count + CNT_ONE;
          if (cpu_en && instr_count != CNT_MAX)
            instr_count <= instr_count + CNT_ONE;
          // A step always ends here; a run ends on HLT, host halt or watchdog.
          if (is_hlt || cmd_halt || wd_hit
              || state == S_STEP) begin
            state  <= S_HALTED;
            busy   <= 1'b0;
            halted <= 1'b1;
            done   <= 1'b1;
            if (is_hlt)
              halt_cause <= C_HLT;
            else if (cmd_halt)
              halt_cause <= C_HOST;
            else if (wd_hit)
              halt_cause <= C_WDOG;
            else
              halt_cause <= C_HOST;
          end
        end
        S_HALTED: begin
          // Only a host halt is resumable; counts carry over.
          if (halt_cause == C_HOST && !cmd_halt
              && (cmd_step || cmd_start)) begin
            state      <= cmd_step ? S_STEP : S_RUN;
            busy       <= 1'b1;
            halted     <= 1'b0;
            halt_cause <= C_NONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bip_run_controller.sv
// tb_bip_run_controller: scoreboard bench for bip_run_controller.
// Directed scenarios then random commands against a cycle reference model.
module tb_bip_run_controller;

  localparam int MAXC = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_start = 1'b0;
  logic        cmd_step = 1'b0;
  logic        cmd_halt = 1'b0;
  logic [4:0]  Opcode = 5'd1;
  logic        WrPC_in = 1'b0;
  logic        WrAcc_in = 1'b0;
  logic        WrRam_in = 1'b0;
  logic        RdRam_in = 1'b0;
  logic        WrPC, WrAcc, WrRam, RdRam;
  logic        cpu_en, busy, halted, done;
  logic [1:0]  halt_cause;
  logic [15:0] cycle_count, instr_count;

  bip_run_controller #(
    .HLT_OPCODE(5'b00000),
    .CNT_W(16),
    .MAX_CYCLES(16'(MAXC))
  ) dut (
    .clock(clock),
    .reset(reset),
    .cmd_start(cmd_start),
    .cmd_step(cmd_step),
    .cmd_halt(cmd_halt),
    .Opcode(Opcode),
    .WrPC_in(WrPC_in),
    .WrAcc_in(WrAcc_in),
    .WrRam_in(WrRam_in),
    .RdRam_in(RdRam_in),
    .WrPC(WrPC),
    .WrAcc(WrAcc),
    .WrRam(WrRam),
    .RdRam(RdRam),
    .cpu_en(cpu_en),
    .busy(busy),
    .halted(halted),
    .done(done),
    .halt_cause(halt_cause),
    .cycle_count(cycle_count),
    .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int n_cyc = 0;
  logic [41:0] exp_q[$];

  // Reference model: 0 idle, 1 run, 2 step, 3 stopped.
  int m_mode = 0;
  int m_cause = 0;
  int m_cyc = 0;
  int m_ins = 0;
  bit m_done = 0;
  bit m_valid = 0;

  function automatic void stop(input int c);
    m_mode = 3;
    m_cause = c;
    m_done = 1;
  endfunction

  function automatic logic [4:0] nz_op();
    return 5'($urandom_range(1, 31));
  endfunction

  task automatic tick(input bit r, input bit st, input bit sp,
                      input bit h, input logic [4:0] op,
                      input logic [3:0] sb);
    logic [41:0] e;
    bit active, exec;
    int prev;
    @(posedge clock);
    #1;
    reset = r;
    cmd_start = st;
    cmd_step = sp;
    cmd_halt = h;
    Opcode = op;
    {WrPC_in, WrAcc_in, WrRam_in, RdRam_in} = sb;
    n_cyc++;
    active = (m_mode == 1 || m_mode == 2);
    exec = active && (op != 5'd0);
    if (m_valid) begin
      e = {sb & {4{exec}}, exec, active, m_mode == 3, m_done,
           2'(m_cause), 16'(m_cyc), 16'(m_ins)};
      exp_q.push_back(e);
    end
    m_done = 0;
    if (r) begin
      m_mode = 0;
      m_cause = 0;
      m_cyc = 0;
      m_ins = 0;
      m_valid = 1;
    end else if (m_valid) begin
      if (m_mode == 0) begin
        if (h) stop(2);
        else if (sp || st) begin
          m_mode = sp ? 2 : 1;
          m_cyc = 0;
          m_ins = 0;
        end
      end else if (active) begin
        prev = m_cyc;
        if (m_cyc < 65535) m_cyc++;
        if (exec && m_ins < 65535) m_ins++;
        if (op == 5'd0) stop(1);
        else if (h) stop(2);
        else if (prev == MAXC - 1) stop(3);
        else if (m_mode == 2) stop(2);
      end else if (m_cause == 2 && !h && (sp || st)) begin
        m_mode = sp ? 2 : 1;
        m_cause = 0;
      end
    end
  endtask

  task automatic run_nz(input int n);
    for (int i = 0; i < n; i++)
      tick(0, 0, 0, 0, nz_op(), 4'($urandom));
  endtask

  always @(negedge clock) begin
    logic [41:0] e, a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {WrPC, WrAcc, WrRam, RdRam, cpu_en, busy, halted, done,
           halt_cause, cycle_count, instr_count};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL cycle%0d outputs got %h want %h", n_cyc, a, e);
      end
    end
  end

  initial begin
    // halt on HLT after five instructions
    tick(1, 0, 0, 0, 5'd1, 4'h0);
    tick(0, 1, 0, 0, nz_op(), 4'hF);
    run_nz(5);
    tick(0, 0, 0, 0, 5'd0, 4'hF);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, nz_op(), 4'hF);
    // single steps
    tick(1, 0, 0, 0, 5'd1, 4'h0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1, 0, nz_op(), 4'hF);
      tick(0, 0, 0, 0, nz_op(), 4'hF);
      tick(0, 0, 0, 0, nz_op(), 4'hF);
    end
    // host halt and resume
    tick(1, 0, 0, 0, 5'd1, 4'h0);
    tick(0, 1, 0, 0, nz_op(), 4'h0);
    run_nz(3);
    tick(0, 0, 0, 1, nz_op(), 4'hF);
    run_nz(2);
    tick(0, 1, 0, 0, nz_op(), 4'hF);
    run_nz(6);
    // watchdog, then commands ignored
    tick(1, 0, 0, 0, 5'd1, 4'h0);
    tick(0, 1, 0, 0, nz_op(), 4'h0);
    run_nz(10);
    tick(0, 1, 0, 0, nz_op(), 4'hF);
    tick(0, 0, 1, 0, nz_op(), 4'hF);
    run_nz(2);
    // all commands together from idle
    tick(1, 0, 0, 0, 5'd1, 4'h0);
    tick(0, 1, 1, 1, nz_op(), 4'hF);
    run_nz(3);
    // reset mid-run with WrRam_in
    tick(1, 0, 0, 0, 5'd1, 4'h0);
    tick(0, 1, 0, 0, nz_op(), 4'h2);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, nz_op(), 4'h2);
    tick(1, 0, 0, 0, nz_op(), 4'h2);
    tick(0, 0, 0, 0, nz_op(), 4'h2);
    tick(0, 0, 0, 0, nz_op(), 4'h2);
    // random traffic
    for (int i = 0; i < 2000; i++) begin
      tick($urandom_range(0, 59) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 11) == 0,
           $urandom_range(0, 14) == 0,
           ($urandom_range(0, 9) == 0) ? 5'd0 : nz_op(),
           4'($urandom));
    end
    tick(0, 0, 0, 0, nz_op(), 4'h0);
    repeat (3) @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain left %0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
